// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-side state encoding, bit-level constants and the
// own-address match used by both the target and the controller FSM.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    // General call (address 0) is never claimed, even if a target is misconfigured to 0.
    function automatic logic is_own_addr(input logic [7:0] addr_byte, input logic [6:0] target);
        return (addr_byte[7:1] == target) && (target != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser plus single-flop edge detector for one asynchronous I2C line.
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target front-end: own-address match, register pointer with auto-increment,
// byte writes out to a register file and byte reads back from it.
//
//   state     | meaning
//   IDLE      | bus free or not addressed, wait START
//   ADDR      | shift 7-bit address + R/W
//   ADDR_ACK  | drive address ACK for one SCL period
//   PTR       | shift register pointer byte
//   PTR_ACK   | drive pointer ACK
//   WR_DATA   | shift write byte
//   WR_ACK    | drive write-data ACK (write issued at its start)
//   RD_DATA   | drive read byte MSB first
//   RD_ACK    | SDA released, sample controller ACK/NACK
//   WAIT_STOP | NACKed read, ignore bus until START/STOP
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter int         DATA_DEPTH     = 8,
    parameter logic [6:0] TARGET_ADDR    = 7'd78,
    parameter int         REG_ADDR_WIDTH = 8,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_scl,
    input  logic                      i_sda,
    output logic                      o_sda_oe,
    output logic                      o_wr_valid,
    output logic [REG_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_DEPTH-1:0]     o_wr_data,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_DEPTH-1:0]     i_rd_data,
    output logic                      o_rd_strobe,
    output logic                      o_busy
);

    if (DATA_DEPTH != 8) begin : g_bad_data_depth
        $error("i2c_target_regs: DATA_DEPTH must be 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("i2c_target_regs: SYNC_STAGES must be at least 2");
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_scl),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_sda),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    logic bus_start, bus_stop;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    i2c_state_t                state, state_nxt;
    logic [DATA_DEPTH-1:0]     shreg, shreg_nxt;
    logic [2:0]                bit_cnt, bit_cnt_nxt;
    logic                      byte_full, byte_full_nxt;
    logic                      rw, rw_nxt;
    logic [REG_ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic                      sda_oe, sda_oe_nxt;
    logic                      busy, busy_nxt;
    logic                      wr_valid, wr_valid_nxt;
    logic [REG_ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [DATA_DEPTH-1:0]     wr_data, wr_data_nxt;
    logic                      rd_strobe, rd_strobe_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_full <= 1'b0;
            rw        <= I2C_WRITE;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_full <= byte_full_nxt;
            rw        <= rw_nxt;
            ptr       <= ptr_nxt;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            wr_valid  <= wr_valid_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            rd_strobe <= rd_strobe_nxt;
        end
    end

    // byte_full marks "8 bits shifted, waiting for the SCL fall that opens the ACK slot";
    // in RD_ACK it marks "controller ACKed, load the next byte on the coming fall".
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        byte_full_nxt = byte_full;
        rw_nxt        = rw;
        ptr_nxt       = ptr;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        wr_valid_nxt  = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        rd_strobe_nxt = 1'b0;

        if (bus_stop) begin
            state_nxt     = IDLE;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            byte_full_nxt = 1'b0;
            bit_cnt_nxt   = '0;
        end else if (bus_start) begin
            state_nxt     = ADDR;
            sda_oe_nxt    = 1'b0;
            byte_full_nxt = 1'b0;
            bit_cnt_nxt   = '0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise && !byte_full) begin
                        shreg_nxt     = {shreg[DATA_DEPTH-2:0], sda_lvl};
                        bit_cnt_nxt   = bit_cnt + 3'd1;
                        byte_full_nxt = (bit_cnt == 3'd7);
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        bit_cnt_nxt   = '0;
                        if (state == ADDR) begin
                            if (is_own_addr(shreg, TARGET_ADDR)) begin
                                state_nxt  = ADDR_ACK;
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                                rw_nxt     = shreg[0];
                            end else begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr_nxt    = REG_ADDR_WIDTH'(shreg);
                            state_nxt  = PTR_ACK;
                            sda_oe_nxt = 1'b1;
                        end else begin
                            wr_valid_nxt = 1'b1;
                            wr_addr_nxt  = ptr;
                            wr_data_nxt  = shreg;
                            ptr_nxt      = ptr + REG_ADDR_WIDTH'(1);
                            state_nxt    = WR_ACK;
                            sda_oe_nxt   = 1'b1;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        if (state == ADDR_ACK && rw == I2C_READ) begin
                            shreg_nxt     = i_rd_data;
                            rd_strobe_nxt = 1'b1;
                            sda_oe_nxt    = ~i_rd_data[DATA_DEPTH-1];
                            state_nxt     = RD_DATA;
                        end else if (state == ADDR_ACK) begin
                            state_nxt = PTR;
                        end else begin
                            state_nxt = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = RD_ACK;
                        end else begin
                            shreg_nxt   = {shreg[DATA_DEPTH-2:0], 1'b0};
                            sda_oe_nxt  = ~shreg[DATA_DEPTH-2];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !byte_full) begin
                        ptr_nxt = ptr + REG_ADDR_WIDTH'(1);
                        if (sda_lvl == NACK) begin
                            state_nxt = WAIT_STOP;
                        end else begin
                            byte_full_nxt = 1'b1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        shreg_nxt     = i_rd_data;
                        rd_strobe_nxt = 1'b1;
                        sda_oe_nxt    = ~i_rd_data[DATA_DEPTH-1];
                        bit_cnt_nxt   = '0;
                        state_nxt     = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_oe    = sda_oe;
    assign o_wr_valid  = wr_valid;
    assign o_wr_addr   = wr_addr;
    assign o_wr_data   = wr_data;
    assign o_rd_addr   = ptr;
    assign o_rd_strobe = rd_strobe;
    assign o_busy      = busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C controller on an open-drain
// SDA model, a small register array behind the read port, and per-scenario checks.
module tb_i2c_target_regs;

    localparam int Q = 80;

    logic       i_clk;
    logic       i_rst_n;
    logic       scl;
    logic       ctrl_sda;
    logic       sda_bus;
    logic       o_sda_oe;
    logic       o_wr_valid;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic [7:0] o_rd_addr;
    logic [7:0] i_rd_data;
    logic       o_rd_strobe;
    logic       o_busy;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int rd_cnt   = 0;
    int busy_cnt = 0;
    int oe_cnt   = 0;

    assign sda_bus   = ctrl_sda & ~o_sda_oe;
    assign i_rd_data = mem[o_rd_addr];

    i2c_target_regs dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_scl       (scl),
        .i_sda       (sda_bus),
        .o_sda_oe    (o_sda_oe),
        .o_wr_valid  (o_wr_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_rd_strobe (o_rd_strobe),
        .o_busy      (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(negedge i_clk) begin
        if (o_wr_valid) begin
            wr_addr_q.push_back(o_wr_addr);
            wr_data_q.push_back(o_wr_data);
        end
        if (o_rd_strobe) rd_cnt <= rd_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
        if (o_sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic bus_start();
        ctrl_sda = 1'b1; #(Q);
        scl = 1'b1;      #(Q);
        ctrl_sda = 1'b0; #(Q);
        scl = 1'b0;      #(Q);
    endtask

    task automatic bus_stop();
        ctrl_sda = 1'b0; #(Q);
        scl = 1'b1;      #(Q);
        ctrl_sda = 1'b1; #(Q);
    endtask

    task automatic wr_bit(input logic b);
        ctrl_sda = b; #(Q);
        scl = 1'b1;   #(2*Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic rd_bit(output logic b);
        ctrl_sda = 1'b1; #(Q);
        scl = 1'b1;      #(Q);
        b = sda_bus;     #(Q);
        scl = 1'b0;      #(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(ack);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; scl = 1'b1; ctrl_sda = 1'b1;
        #100;
        total++; if (o_sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b want=0", o_sda_oe); end
        total++; if (o_wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b want=0", o_wr_valid); end
        total++; if (o_rd_strobe !== 1'b0) begin bad++; $display("FAIL rst_rd_strobe got=%b want=0", o_rd_strobe); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        total++; if (o_rd_addr !== 8'h00) begin bad++; $display("FAIL rst_rd_addr got=%h want=00", o_rd_addr); end
        total++; if ({o_wr_addr, o_wr_data} !== 16'h0000) begin bad++; $display("FAIL rst_wr_bus got=%h want=0000", {o_wr_addr, o_wr_data}); end
        i_rst_n = 1'b1;
        #200;
        total++; if ({o_sda_oe, o_busy} !== 2'b00) begin bad++; $display("FAIL post_rst_idle got=%b want=00", {o_sda_oe, o_busy}); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, busy_mid;
        int n0 = wr_addr_q.size();
        bus_start();
        send_byte(8'h9C, a0);
        busy_mid = o_busy;
        send_byte(8'h09, a1);
        send_byte(8'h04, a2);
        bus_stop();
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wr_acks got=%b want=000", {a0, a1, a2}); end
        total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b want=1", busy_mid); end
        total++; if (wr_addr_q.size() - n0 !== 1) begin bad++; $display("FAIL wr_count got=%0d want=1", wr_addr_q.size() - n0); end
        total++; if (wr_addr_q[n0] !== 8'h09) begin bad++; $display("FAIL wr_addr got=%h want=09", wr_addr_q[n0]); end
        total++; if (wr_data_q[n0] !== 8'h04) begin bad++; $display("FAIL wr_data got=%h want=04", wr_data_q[n0]); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b want=0", o_busy); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1, b2;
        int r0 = rd_cnt;
        int n0 = wr_addr_q.size();
        mem[3] = 8'hA5; mem[4] = 8'h5A; mem[5] = 8'hC3;
        bus_start();
        send_byte(8'h9C, a0);
        send_byte(8'h03, a1);
        bus_start();
        send_byte(8'h9D, a2);
        recv_byte(b0, 1'b0);
        recv_byte(b1, 1'b0);
        recv_byte(b2, 1'b1);
        bus_stop();
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rd_acks got=%b want=000", {a0, a1, a2}); end
        total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL rd_byte0 got=%h want=a5", b0); end
        total++; if (b1 !== 8'h5A) begin bad++; $display("FAIL rd_byte1 got=%h want=5a", b1); end
        total++; if (b2 !== 8'hC3) begin bad++; $display("FAIL rd_byte2 got=%h want=c3", b2); end
        total++; if (rd_cnt - r0 !== 3) begin bad++; $display("FAIL rd_strobes got=%0d want=3", rd_cnt - r0); end
        total++; if (o_rd_addr !== 8'h06) begin bad++; $display("FAIL rd_final_addr got=%h want=06", o_rd_addr); end
        total++; if (wr_addr_q.size() - n0 !== 0) begin bad++; $display("FAIL rd_no_writes got=%0d want=0", wr_addr_q.size() - n0); end
        total++; if ({o_sda_oe, o_busy} !== 2'b00) begin bad++; $display("FAIL rd_after_stop got=%b want=00", {o_sda_oe, o_busy}); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        int r0 = rd_cnt;
        int bz0 = busy_cnt;
        int oe0 = oe_cnt;
        int n0 = wr_addr_q.size();
        bus_start();
        send_byte(8'h9E, a0);
        send_byte(8'h55, a1);
        bus_stop();
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL bad_addr_ack got=%b want=1", a0); end
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL bad_addr_data_ack got=%b want=1", a1); end
        total++; if (busy_cnt - bz0 !== 0) begin bad++; $display("FAIL bad_addr_busy got=%0d want=0", busy_cnt - bz0); end
        total++; if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL bad_addr_sda_oe got=%0d want=0", oe_cnt - oe0); end
        total++; if ((rd_cnt - r0) + (wr_addr_q.size() - n0) !== 0) begin bad++; $display("FAIL bad_addr_strobes got=%0d want=0", (rd_cnt - r0) + (wr_addr_q.size() - n0)); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        int n0 = wr_addr_q.size();
        bus_start();
        send_byte(8'h9C, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        bus_stop();
        total++; if ({a0, a1, a2, a3} !== 4'b0000) begin bad++; $display("FAIL wrap_acks got=%b want=0000", {a0, a1, a2, a3}); end
        total++; if (wr_addr_q.size() - n0 !== 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", wr_addr_q.size() - n0); end
        total++; if ({wr_addr_q[n0], wr_data_q[n0]} !== 16'hFF11) begin bad++; $display("FAIL wrap_first got=%h want=ff11", {wr_addr_q[n0], wr_data_q[n0]}); end
        total++; if ({wr_addr_q[n0+1], wr_data_q[n0+1]} !== 16'h0022) begin bad++; $display("FAIL wrap_second got=%h want=0022", {wr_addr_q[n0+1], wr_data_q[n0+1]}); end
        total++; if (o_rd_addr !== 8'h01) begin bad++; $display("FAIL wrap_ptr got=%h want=01", o_rd_addr); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, a3, a4;
        int n0 = wr_addr_q.size();
        bus_start();
        send_byte(8'h9C, a0);
        send_byte(8'h20, a1);
        wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1);
        bus_stop();
        total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL abort_acks got=%b want=00", {a0, a1}); end
        total++; if (wr_addr_q.size() - n0 !== 0) begin bad++; $display("FAIL abort_no_write got=%0d want=0", wr_addr_q.size() - n0); end
        total++; if ({o_sda_oe, o_busy} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b want=00", {o_sda_oe, o_busy}); end
        total++; if (o_rd_addr !== 8'h20) begin bad++; $display("FAIL abort_ptr got=%h want=20", o_rd_addr); end
        bus_start();
        send_byte(8'h9C, a2);
        send_byte(8'h30, a3);
        send_byte(8'h77, a4);
        bus_stop();
        total++; if ({a2, a3, a4} !== 3'b000) begin bad++; $display("FAIL abort_next_acks got=%b want=000", {a2, a3, a4}); end
        total++; if ({wr_addr_q[n0], wr_data_q[n0]} !== 16'h3077) begin bad++; $display("FAIL abort_next_write got=%h want=3077", {wr_addr_q[n0], wr_data_q[n0]}); end
    endtask

    task automatic test_reset_mid_ack();
        logic a0, a1;
        bus_start();
        send_byte(8'h9C, a0);
        send_byte(8'h40, a1);
        for (int i = 7; i >= 0; i--) wr_bit(i[0]);
        ctrl_sda = 1'b1; #(Q);
        scl = 1'b1;      #(Q);
        total++; if (o_sda_oe !== 1'b1) begin bad++; $display("FAIL mid_ack_driving got=%b want=1", o_sda_oe); end
        i_rst_n = 1'b0;
        #1;
        total++; if (o_sda_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_sda_oe got=%b want=0", o_sda_oe); end
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL mid_rst_sda_line got=%b want=1", sda_bus); end
        total++; if ({o_busy, o_wr_valid, o_rd_strobe} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got=%b want=000", {o_busy, o_wr_valid, o_rd_strobe}); end
        total++; if ({o_rd_addr, o_wr_addr, o_wr_data} !== 24'h000000) begin bad++; $display("FAIL mid_rst_buses got=%h want=000000", {o_rd_addr, o_wr_addr, o_wr_data}); end
        #(2*Q-1);
        i_rst_n = 1'b1;
        #(Q);
        total++; if ({o_sda_oe, o_busy} !== 2'b00) begin bad++; $display("FAIL mid_rst_release got=%b want=00", {o_sda_oe, o_busy}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_wrap();
        test_abort();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
